// File: rtl/des_key_schedule_pkg.sv
// DES key-schedule shared definitions.
// Permutation tables, shift schedules, FSM states.
package des_key_schedule_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entry 0 is the load-time rotation; C16 == C0.
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  function automatic logic [1:28] rot28(
    input logic [1:28] x,
    input logic        right,
    input logic [1:0]  amt
  );
    logic [1:28] r;
    r = x;
    case ({right, amt})
      3'b001:  r = {x[2:28], x[1]};
      3'b010:  r = {x[3:28], x[1:2]};
      3'b101:  r = {x[28], x[1:27]};
      3'b110:  r = {x[27:28], x[1:26]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Request and subkey handshake bundle
// for the DES key-schedule generator.
interface des_key_schedule_if;
  logic        start;
  logic [1:64] key;
  logic        decrypt;
  logic        subkey_ready;
  logic [1:48] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, key, decrypt, subkey_ready,
    input  subkey, subkey_valid, round_idx,
    input  busy, done
  );

  modport slave (
    input  start, key, decrypt, subkey_ready,
    output subkey, subkey_valid, round_idx,
    output busy, done
  );
endinterface

// File: rtl/des_pc2.sv
// DES permuted choice 2: 56-bit C||D
// to 48-bit round subkey, wiring only.
module des_pc2
  import des_key_schedule_pkg::*;
(
  input  logic [1:56] cd,
  output logic [1:48] k
);

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign k[i+1] = cd[PC2[i]];
  end

  // Bits PC-2 discards by definition.
  logic unused_bits;
  assign unused_bits = ^{cd[9], cd[18], cd[22],
                         cd[25], cd[35], cd[38],
                         cd[43], cd[54]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: issues
// K1..K16 or K16..K1 over valid/ready.
module des_key_schedule
  import des_key_schedule_pkg::*;
(
  input logic clk,
  input logic rst,
  des_key_schedule_if.slave bus
);

  state_t      state;
  state_t      state_n;
  logic [1:28] c;
  logic [1:28] d;
  logic [3:0]  cnt;
  logic [3:0]  nxt;
  logic        dec;
  logic [1:56] pc1_key;
  logic [1:48] pc2_out;
  logic        fire;
  logic        last;
  logic        accept;
  logic [1:0]  load_amt;
  logic [1:0]  step_amt;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[i+1] = bus.key[PC1[i]];
  end

  logic unused_parity;
  assign unused_parity = ^{bus.key[8], bus.key[16],
                           bus.key[24], bus.key[32],
                           bus.key[40], bus.key[48],
                           bus.key[56], bus.key[64]};

  assign fire   = bus.subkey_valid & bus.subkey_ready;
  assign last   = fire & (cnt == 4'd15);
  assign accept = (state == IDLE) & bus.start;
  assign nxt    = cnt + 4'd1;

  assign load_amt = bus.decrypt ? DEC_SHIFT[0]
                                : ENC_SHIFT[0];
  assign step_amt = dec ? DEC_SHIFT[nxt]
                        : ENC_SHIFT[nxt];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.subkey_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.subkey_valid <= (state_n == RUN);
      bus.busy         <= (state_n == RUN);
      bus.done         <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      d   <= '0;
      cnt <= '0;
      dec <= 1'b0;
    end else if (accept) begin
      dec <= bus.decrypt;
      cnt <= '0;
      c   <= rot28(pc1_key[1:28], bus.decrypt, load_amt);
      d   <= rot28(pc1_key[29:56], bus.decrypt, load_amt);
    end else if (fire) begin
      cnt <= nxt;
      if (!last) begin
        c <= rot28(c, dec, step_amt);
        d <= rot28(d, dec, step_amt);
      end
    end
  end

  des_pc2 u_pc2 (
    .cd ({c, d}),
    .k  (pc2_out)
  );

  assign bus.subkey    = bus.subkey_valid ? pc2_out : '0;
  assign bus.round_idx = cnt;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule
// using the classic FIPS worked-example key.
module tb_des_key_schedule;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_schedule_if bus();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEYP = 64'h123556789ABDDEF0;

  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5,
    48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F,
    48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F,
    48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A,
    48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [3:0]  idx;
    logic [47:0] sk;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last15 = -100;
  int dones = 0;
  int dones_exp = 0;
  bit stall_p = 1'b0;
  logic [47:0] held_sk;
  logic [3:0] held_idx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (stall_p && bus.subkey_valid) begin
      chk("stall_subkey", bus.subkey, held_sk);
      chk("stall_idx", bus.round_idx, held_idx);
    end
    stall_p  = bus.subkey_valid && !bus.subkey_ready;
    held_sk  = bus.subkey;
    held_idx = bus.round_idx;
    if (!bus.subkey_valid)
      chk("gated_subkey", bus.subkey, 0);
    chk("done_with_valid",
        bus.done & bus.subkey_valid, 0);
    if (bus.subkey_valid && bus.subkey_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer: idx %0d",
                 bus.round_idx);
      end else begin
        e = sb.pop_front();
        chk("round_idx", bus.round_idx, e.idx);
        chk("subkey", bus.subkey, e.sk);
      end
      if (bus.round_idx == 4'd15) last15 = cyc;
    end
    if (bus.done) begin
      dones++;
      chk("done_after_last", cyc, last15 + 1);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, bus.subkey_valid, 0);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_done"}, bus.done, 0);
  endtask

  task automatic push_seq(input logic dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.idx = 4'(i);
      e.sk  = dec ? KS[15-i] : KS[i];
      sb.push_back(e);
    end
  endtask

  task automatic run(input logic [63:0] k,
                     input logic dec,
                     input bit rnd,
                     input int inj,
                     input int rst_at);
    int n;
    bit seen;
    push_seq(dec);
    if (rst_at < 0) dones_exp++;
    bus.key = k;
    bus.decrypt = dec;
    bus.start = 1'b1;
    bus.subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    step;
    bus.start = 1'b0;
    bus.key = ~k;
    bus.decrypt = ~dec;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (rst_at >= 0 && bus.subkey_valid &&
            bus.round_idx == 4'(rst_at)) begin
          rst = 1'b1;
          step;
          rst = 1'b0;
          sb.delete();
          chk("rst_subkey", bus.subkey, 0);
          chk("rst_idx", bus.round_idx, 0);
          chk_idle("rst");
          return;
        end
        if (inj >= 0 && bus.subkey_valid &&
            bus.round_idx == 4'(inj)) begin
          bus.start = 1'b1;
          bus.key = '1;
        end else begin
          bus.start = 1'b0;
        end
        bus.subkey_ready = rnd ? 1'($urandom_range(0, 1))
                               : 1'b1;
        step;
        n++;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done in %0d cycles", n);
      return;
    end
    if (!rnd) chk("done_latency", n, 16);
    chk("done_busy", bus.busy, 0);
    chk("done_valid", bus.subkey_valid, 0);
    // start raised during the DONE cycle must be dropped.
    bus.start = 1'b1;
    bus.key = k;
    step;
    bus.start = 1'b0;
    chk_idle("post_done1");
    step;
    chk_idle("post_done2");
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.decrypt = 1'b0;
    bus.subkey_ready = 1'b0;
    step;
    step;
    chk("reset_subkey", bus.subkey, 0);
    chk("reset_idx", bus.round_idx, 0);
    chk_idle("reset");
    rst = 1'b0;
    step;

    run(KEY, 1'b0, 1'b0, -1, -1);
    run(KEY, 1'b1, 1'b0, -1, -1);
    run(KEY, 1'b0, 1'b1, -1, -1);
    run(KEY, 1'b1, 1'b1, -1, -1);
    run(KEY, 1'b0, 1'b0, 5, -1);
    run(KEY, 1'b0, 1'b0, -1, 7);
    run(KEY, 1'b0, 1'b0, -1, -1);

    rst = 1'b1;
    bus.start = 1'b1;
    bus.key = KEY;
    bus.decrypt = 1'b0;
    step;
    rst = 1'b0;
    bus.start = 1'b0;
    chk_idle("rst_start1");
    step;
    chk_idle("rst_start2");

    run(KEYP, 1'b0, 1'b0, -1, -1);
    run(KEYP, 1'b1, 1'b1, -1, -1);

    step;
    chk("sb_empty", sb.size(), 0);
    chk("done_count", dones, dones_exp);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
